// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the programmable serial sequence detector.
package seq_det_pkg;
    typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_t;

    localparam int         DEF_PAT_LEN = 4;
    localparam int         DEF_CNT_W   = 8;
    localparam logic [3:0] DEF_PATTERN = 4'b0110;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end
endmodule

// File: rtl/seq_detector_prog.sv
// Serial pattern detector with a loadable pattern, overlap control and a saturating match count.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter int                 CNT_W   = DEF_CNT_W,
    parameter logic [PAT_LEN-1:0] DEF_PAT = PAT_LEN'(DEF_PATTERN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               load_pat,
    input  logic               overlap_en,
    input  logic               clear_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);
    localparam int            FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    state_t             state;
    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill_next;
    logic               hit;

    // Decision is made on the post-shift history so match lands on the sampling edge.
    always_comb begin
        hist_next = {hist[PAT_LEN-2:0], din};
        fill_next = (fill == FULL) ? FULL : fill + FW'(1);
        hit       = din_valid && !load_pat && (hist_next == pat) && (fill_next == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            pat   <= DEF_PAT;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (load_pat) begin
                pat   <= pattern;
                fill  <= '0;
                state <= FILL;
            end else if (din_valid) begin
                hist <= hist_next;
                // Non-overlapping mode restarts the fill so bits of this match are not reused.
                if (hit && !overlap_en) begin
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    fill  <= fill_next;
                    state <= (fill_next == FULL) ? ARMED : FILL;
                end
            end
        end
    end

    assign armed = (state == ARMED);

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (clear_cnt),
        .count (match_count)
    );
endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, meaning the pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the match-counter width.
REQ-003 SHALL have parameter DEF_PAT, default 4'b0110 (PAT_LEN bits), meaning the pattern loaded at reset.
REQ-004 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port din, input, 1, serial data bit.
REQ-007 SHALL have port din_valid, input, 1, din sampled only when high.
REQ-008 SHALL have port pattern, input, PAT_LEN, new pattern value, MSB is the first bit expected on the line.
REQ-009 SHALL have port load_pat, input, 1, one-cycle strobe capturing pattern.
REQ-010 SHALL have port overlap_en, input, 1, 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-011 SHALL have port clear_cnt, input, 1, synchronous clear of match_count.
REQ-012 SHALL have port match, output, 1, registered one-cycle pulse on detection.
REQ-013 SHALL have port match_count, output, CNT_W, saturating count of matches.
REQ-014 SHALL have port armed, output, 1, high when at least PAT_LEN valid bits are held in history.

Function
REQ-015 SHALL keep a PAT_LEN-bit history shift register; on a valid edge shift left and insert din at bit 0.
REQ-016 SHALL keep a fill counter (0..PAT_LEN, saturating) of valid bits accepted since the last reset, load or non-overlap match.
REQ-017 SHALL implement two states: FILL (fill < PAT_LEN) and ARMED (fill = PAT_LEN); armed = (state == ARMED).
REQ-018 SHALL assert match for exactly one cycle after the edge at which a valid bit makes the updated history equal the stored pattern with the updated fill = PAT_LEN (zero-cycle latency from the sampling edge to the registered output).
REQ-019 SHALL hold match low on any edge with din_valid = 0; history, fill and state SHALL hold.
REQ-020 SHALL, on match with overlap_en = 1, keep history and stay ARMED (e.g. 0110110 with pattern 0110 yields 2 matches).
REQ-021 SHALL, on match with overlap_en = 0, reset fill to 0 and go to FILL (0110110 yields 1 match).
REQ-022 SHALL, on load_pat = 1, capture pattern, set fill = 0, state FILL, force match = 0, and ignore din in that cycle; match_count SHALL be unaffected.
REQ-023 SHALL increment match_count by 1 on each match and saturate at 2^CNT_W-1 without wrapping.
REQ-024 SHALL give clear_cnt priority over an increment in the same cycle (result 0).
REQ-025 SHALL sample overlap_en per valid edge; a change takes effect on the next match decision.

Reset
REQ-026 SHALL, while reset = 0, asynchronously force match = 0, match_count = 0, armed = 0, history = 0, fill = 0, state FILL and stored pattern = DEF_PAT.
REQ-027 SHALL, on reset assertion mid-sequence, discard all partial history; detection restarts from the first valid bit after release.

Structure
REQ-028 SHALL place the state enum (FILL, ARMED) and the default PAT_LEN/CNT_W/DEF_PAT constants in the shared package seq_det_pkg.
REQ-029 SHALL implement match_count as the sub-module sat_counter (parameter W; inputs inc, clr; clr has priority; saturates).
REQ-030 SHALL keep the RTL free of combinational paths from inputs to outputs.

Verification
REQ-031 SHALL cover defaults: release reset, drive valid bits 0,1,1,0 -> match pulses once after the 4th edge, match_count = 1.
REQ-032 SHALL cover overlap: stream 0110110 with overlap_en = 1 -> 2 matches; repeat after reset with overlap_en = 0 -> 1 match.
REQ-033 SHALL cover load: load_pat with pattern 1011 mid-stream, then bits 1,0,1,1 -> match only after the 4th post-load bit, armed low for the first 3.
REQ-034 SHALL cover valid gaps: 0,1,(gap x3),1,0 -> match after the final bit; no match during gaps.
REQ-035 SHALL cover saturation and clear: CNT_W = 2, 5 matches -> match_count = 3; clear_cnt with a simultaneous match -> 0.
REQ-036 SHALL cover asynchronous reset: assert reset between clock edges after 0,1,1 -> outputs 0 immediately; then 0 -> no match.
